conv_sched: RTL and testbench

//  Top-level sequencer for the 64x64 3x3-conv engine (layer0) and the 2x2 max-pool stage behind it.

---
 rtl/conv_sched.sv | 214 +++++++++++++++++++++
 tb/tb_conv_sched.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sched.sv
// conv_sched: top-level sequencer for the layer0 3x3 conv engine and the 2x2 max-pool stage.
// Starts layer0, releases it one row pair at a time with pool-FIFO back-pressure, and owns
// the single result-memory write port (conv results win, pool results queue in a small FIFO).
// Optional build macro RELU_EN: when defined, negative conv results are written as zero.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for i_start, o_busy low
// S_START   | one-cycle o_l0_ready pulse to layer0
// S_WAIT    | waiting for layer0 to report busy
// S_RUN     | layer0 producing the current row pair
// S_PAUSE   | row pair done; hold layer0 until the pool FIFO has room
// S_DRAIN   | last row pair done; waiting for all pool results to be written
// S_DONE    | one-cycle o_done pulse
module conv_sched #(
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int DW         = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_l0_ready,
  output logic          o_l0_go_down,
  input  logic          i_l0_busy,
  input  logic          i_l0_valid,
  input  logic [DW-1:0] i_l0_data,
  input  logic          i_pool_valid,
  input  logic [DW-1:0] i_pool_data,
  output logic          o_pool_ready,
  output logic          o_csel,
  output logic          o_cwr,
  output logic [11:0]   o_caddr,
  output logic [DW-1:0] o_cdata
);

  // pair_cnt must reach 2*IMG_W itself, so it needs one bit more than the index range
  localparam int PAIR_W = $clog2(2*IMG_W + 1);
  localparam int ROWP_W = (IMG_H/2 > 1) ? $clog2(IMG_H/2) : 1;
  localparam int POOL_N = (IMG_W/2) * (IMG_H/2);
  localparam int POOL_W = $clog2(POOL_N + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);

  localparam logic [PAIR_W-1:0] PAIR_LEN  = PAIR_W'(2*IMG_W);
  localparam logic [ROWP_W-1:0] LAST_ROWP = ROWP_W'(IMG_H/2 - 1);
  localparam logic [POOL_W-1:0] POOL_LAST = POOL_W'(POOL_N);
  localparam logic [AW:0]       FIFO_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]       GO_LEVEL  = (AW+1)'(FIFO_DEPTH - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_RUN, S_PAUSE, S_DRAIN, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [11:0]       conv_cnt_q;
  logic [PAIR_W-1:0] pair_cnt_q;
  logic [ROWP_W-1:0] rowp_cnt_q;
  logic [POOL_W-1:0] pool_cnt_q;

  logic [DW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fifo_cnt_q;

  logic          cwr_q, csel_q;
  logic [11:0]   caddr_q;
  logic [DW-1:0] cdata_q;

  logic          img_clr, pair_clr, rowp_inc, go_down;
  logic          conv_acc, pool_push, pool_pop, pool_wr;
  logic [DW-1:0] conv_wdata;

  // write-port arbitration: a conv result always takes the port; the FIFO head only moves
  // on conv-free cycles, and heads beyond the image's pool count are discarded
  always_comb begin
    conv_acc  = i_l0_valid && (state_q != S_IDLE);
    pool_pop  = !conv_acc && (fifo_cnt_q != '0);
    pool_wr   = pool_pop && (pool_cnt_q != POOL_LAST);
    pool_push = i_pool_valid && o_pool_ready;
  end

  // conv data as written to memory
  always_comb begin
`ifdef RELU_EN
    conv_wdata = i_l0_data[DW-1] ? '0 : i_l0_data;
`else
    conv_wdata = i_l0_data;
`endif
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state and sequencing controls
  always_comb begin
    state_d  = state_q;
    img_clr  = 1'b0;
    pair_clr = 1'b0;
    rowp_inc = 1'b0;
    go_down  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          img_clr = 1'b1;
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT:  if (i_l0_busy) state_d = S_RUN;
      S_RUN: begin
        if ((pair_cnt_q == PAIR_LEN) && !i_l0_busy) begin
          pair_clr = 1'b1;
          rowp_inc = 1'b1;
          state_d  = (rowp_cnt_q == LAST_ROWP) ? S_DRAIN : S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (fifo_cnt_q <= GO_LEVEL) begin
          go_down = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_DRAIN: begin
        if ((pool_cnt_q == POOL_LAST) && (fifo_cnt_q == '0) && !cwr_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // image counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conv_cnt_q <= '0;
      pair_cnt_q <= '0;
      rowp_cnt_q <= '0;
      pool_cnt_q <= '0;
    end else if (img_clr) begin
      conv_cnt_q <= '0;
      pair_cnt_q <= '0;
      rowp_cnt_q <= '0;
      pool_cnt_q <= '0;
    end else begin
      if (conv_acc) conv_cnt_q <= conv_cnt_q + 1'b1;
      if (pair_clr) pair_cnt_q <= '0;
      else if (conv_acc && (pair_cnt_q != PAIR_LEN)) pair_cnt_q <= pair_cnt_q + 1'b1;
      if (rowp_inc) rowp_cnt_q <= rowp_cnt_q + 1'b1;
      if (pool_wr)  pool_cnt_q <= pool_cnt_q + 1'b1;
    end
  end

  // pool FIFO storage (contents need no reset; occupancy gates every read)
  always_ff @(posedge clk) begin
    if (pool_push) fifo_mem[wr_ptr_q] <= i_pool_data;
  end

  // pool FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (pool_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pool_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({pool_push, pool_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // registered result-memory write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cwr_q   <= 1'b0;
      csel_q  <= 1'b0;
      caddr_q <= '0;
      cdata_q <= '0;
    end else begin
      cwr_q <= conv_acc || pool_wr;
      if (conv_acc) begin
        csel_q  <= 1'b0;
        caddr_q <= conv_cnt_q;
        cdata_q <= conv_wdata;
      end else if (pool_wr) begin
        csel_q  <= 1'b1;
        caddr_q <= 12'(pool_cnt_q);
        cdata_q <= fifo_mem[rd_ptr_q];
      end else begin
        csel_q  <= 1'b0;
      end
    end
  end

  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_DONE);
  assign o_l0_ready   = (state_q == S_START);
  assign o_l0_go_down = go_down;
  // pool sink is only serviced while an image is in flight
  assign o_pool_ready = (state_q != S_IDLE) && (fifo_cnt_q != FIFO_FULL);
  assign o_cwr        = cwr_q;
  assign o_csel       = csel_q;
  assign o_caddr      = caddr_q;
  assign o_cdata      = cdata_q;

endmodule

// File: tb/tb_conv_sched.sv
// Directed self-checking bench for conv_sched (64x64 image, DW=19, 4-entry pool FIFO).
module tb_conv_sched;
  localparam int DW = 19;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_start = 1'b0;
  logic          i_l0_busy = 1'b0;
  logic          i_l0_valid = 1'b0;
  logic [DW-1:0] i_l0_data = '0;
  logic          i_pool_valid = 1'b0;
  logic [DW-1:0] i_pool_data = '0;
  logic          o_busy, o_done, o_l0_ready, o_l0_go_down, o_pool_ready;
  logic          o_csel, o_cwr;
  logic [11:0]   o_caddr;
  logic [DW-1:0] o_cdata;

  int checks = 0;
  int errors = 0;

  conv_sched #(.IMG_W(64), .IMG_H(64), .DW(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_l0_ready(o_l0_ready), .o_l0_go_down(o_l0_go_down),
    .i_l0_busy(i_l0_busy), .i_l0_valid(i_l0_valid), .i_l0_data(i_l0_data),
    .i_pool_valid(i_pool_valid), .i_pool_data(i_pool_data), .o_pool_ready(o_pool_ready),
    .o_csel(o_csel), .o_cwr(o_cwr), .o_caddr(o_caddr), .o_cdata(o_cdata)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] outs();
    return {o_busy, o_done, o_l0_ready, o_l0_go_down, o_pool_ready, o_csel, o_cwr, o_caddr, o_cdata};
  endfunction

  function automatic logic [32:0] wr_vec();
    return {o_cwr, o_csel, o_caddr, o_cdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_start = 0; i_l0_busy = 0; i_l0_valid = 0; i_l0_data = '0;
    i_pool_valid = 0; i_pool_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    tick();
  endtask

  // leaves the bench in the START cycle
  task automatic start_image();
    i_start = 1;
    tick();
    i_start = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 reset = 1;
    #2;
    checks++;
    if (outs() !== 38'd0) begin errors++; $display("FAIL reset_outputs got %h exp 0", outs()); end
    tick(); tick();
    reset = 0;
    tick();
    checks++;
    if (outs() !== 38'd0) begin errors++; $display("FAIL idle_outputs got %h exp 0", outs()); end
    i_l0_valid = 1; i_l0_data = 19'h00042;
    tick();
    i_l0_valid = 0;
    tick();
    checks++;
    if (o_cwr !== 1'b0) begin errors++; $display("FAIL idle_conv_ignored got cwr=%b exp 0", o_cwr); end
  endtask

  task automatic test_relu();
    logic [DW-1:0] exp_neg;
`ifdef RELU_EN
    exp_neg = '0;
`else
    exp_neg = 19'h7FFF0;
`endif
    do_reset();
    start_image();
    tick();
    i_l0_valid = 1; i_l0_data = 19'h7FFF0;
    tick();
    checks++;
    if (wr_vec() !== {1'b1, 1'b0, 12'd0, exp_neg}) begin
      errors++; $display("FAIL relu_negative got %h exp %h", wr_vec(), {1'b1, 1'b0, 12'd0, exp_neg});
    end
    i_l0_data = 19'h00123;
    tick();
    i_l0_valid = 0;
    checks++;
    if (wr_vec() !== {1'b1, 1'b0, 12'd1, 19'h00123}) begin
      errors++; $display("FAIL relu_positive got %h exp %h", wr_vec(), {1'b1, 1'b0, 12'd1, 19'h00123});
    end
  endtask

  task automatic test_collision();
    do_reset();
    start_image();
    tick();
    checks++;
    if (o_pool_ready !== 1'b1) begin errors++; $display("FAIL coll_ready got %b exp 1", o_pool_ready); end
    i_pool_valid = 1; i_pool_data = 19'h1ABCD;
    tick();
    i_pool_valid = 0;
    i_l0_valid = 1; i_l0_data = 19'h00011;
    checks++;
    if (o_cwr !== 1'b0) begin errors++; $display("FAIL coll_nowrite got %b exp 0", o_cwr); end
    tick();
    checks++;
    if (wr_vec() !== {1'b1, 1'b0, 12'd0, 19'h00011}) begin
      errors++; $display("FAIL coll_conv0 got %h exp %h", wr_vec(), {1'b1, 1'b0, 12'd0, 19'h00011});
    end
    i_l0_data = 19'h00022;
    tick();
    i_l0_valid = 0;
    checks++;
    if (wr_vec() !== {1'b1, 1'b0, 12'd1, 19'h00022}) begin
      errors++; $display("FAIL coll_conv1 got %h exp %h", wr_vec(), {1'b1, 1'b0, 12'd1, 19'h00022});
    end
    tick();
    checks++;
    if (wr_vec() !== {1'b1, 1'b1, 12'd0, 19'h1ABCD}) begin
      errors++; $display("FAIL coll_pool got %h exp %h", wr_vec(), {1'b1, 1'b1, 12'd0, 19'h1ABCD});
    end
  endtask

  task automatic test_start_ignored();
    int rdy = 0;
    logic [11:0] last_addr = '0;
    do_reset();
    start_image();
    tick();
    for (int k = 0; k < 10; k++) begin
      i_l0_busy = 1; i_l0_valid = 1; i_l0_data = DW'(k);
      i_start = (k == 5);
      tick();
      if (o_l0_ready) rdy++;
      if (o_cwr && !o_csel) last_addr = o_caddr;
    end
    i_l0_valid = 0; i_start = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (o_l0_ready) rdy++;
    end
    checks++;
    if (rdy !== 0) begin errors++; $display("FAIL start_no_ready got %0d exp 0", rdy); end
    checks++;
    if (last_addr !== 12'd9) begin errors++; $display("FAIL start_last_addr got %0d exp 9", last_addr); end
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b exp 1", o_busy); end
    i_l0_valid = 1; i_l0_data = 19'd99;
    tick();
    i_l0_valid = 0;
    checks++;
    if (wr_vec() !== {1'b1, 1'b0, 12'd10, 19'd99}) begin
      errors++; $display("FAIL start_cont_addr got %h exp %h", wr_vec(), {1'b1, 1'b0, 12'd10, 19'd99});
    end
  endtask

  task automatic test_pause_flood();
    int go_flood = 0;
    do_reset();
    start_image();
    tick();
    for (int k = 0; k < 128; k++) begin
      i_l0_busy = 1; i_l0_valid = 1; i_l0_data = DW'(k);
      i_pool_valid = (k < 4); i_pool_data = 19'h00100 + DW'(k);
      tick();
    end
    i_l0_busy = 0; i_l0_valid = 0;
    i_pool_valid = 1; i_pool_data = 19'h001FF;
    checks++;
    if (o_pool_ready !== 1'b0) begin errors++; $display("FAIL flood_full_ready got %b exp 0", o_pool_ready); end
    tick();
    checks++;
    if (wr_vec() !== {1'b1, 1'b1, 12'd0, 19'h00100}) begin
      errors++; $display("FAIL flood_pool0 got %h exp %h", wr_vec(), {1'b1, 1'b1, 12'd0, 19'h00100});
    end
    if (o_l0_go_down) go_flood++;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (o_l0_go_down) go_flood++;
    end
    checks++;
    if (go_flood !== 0) begin errors++; $display("FAIL flood_go_held got %0d exp 0", go_flood); end
    i_pool_valid = 0;
    tick();
    checks++;
    if (o_l0_go_down !== 1'b1) begin errors++; $display("FAIL flood_go_release got %b exp 1", o_l0_go_down); end
    tick();
    checks++;
    if (o_l0_go_down !== 1'b0) begin errors++; $display("FAIL flood_go_single got %b exp 0", o_l0_go_down); end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    do_reset();
    start_image();
    tick();
    for (int k = 0; k < 700; k++) begin
      i_l0_busy = 1; i_l0_valid = 1; i_l0_data = DW'(k);
      i_pool_valid = (k < 2); i_pool_data = 19'h00200 + DW'(k);
      tick();
    end
    checks++;
    if ({o_cwr, o_csel, o_caddr} !== {1'b1, 1'b0, 12'd699}) begin
      errors++; $display("FAIL mid_addr699 got %h exp %h", {o_cwr, o_csel, o_caddr}, {1'b1, 1'b0, 12'd699});
    end
    clear_inputs();
    reset = 1;
    #2;
    checks++;
    if (outs() !== 38'd0) begin errors++; $display("FAIL mid_reset_now got %h exp 0", outs()); end
    tick();
    checks++;
    if (outs() !== 38'd0) begin errors++; $display("FAIL mid_reset_next got %h exp 0", outs()); end
    reset = 0;
    tick();
    start_image();
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      if (o_cwr) stale++;
    end
    checks++;
    if (stale !== 0) begin errors++; $display("FAIL mid_fifo_empty got %0d writes exp 0", stale); end
    i_l0_valid = 1; i_l0_data = 19'h00055;
    tick();
    i_l0_valid = 0;
    checks++;
    if (wr_vec() !== {1'b1, 1'b0, 12'd0, 19'h00055}) begin
      errors++; $display("FAIL mid_restart got %h exp %h", wr_vec(), {1'b1, 1'b0, 12'd0, 19'h00055});
    end
  endtask

  task automatic test_full_image();
    int rem = 0, owed = 0, conv_sent = 0, pool_sent = 0, cyc = 0;
    int conv_wr = 0, pool_wr = 0, conv_bad = 0, pool_bad = 0, lat_bad = 0;
    int go_cnt = 0, rdy_cnt = 0, done_cnt = 0, busy_bad = 0;
    logic start_next = 0, prev_valid = 0, done_seen = 0, busy_after = 1;
    do_reset();
    start_image();
    while (cyc < 20000) begin
      if (o_cwr && !o_csel) begin
        if (o_caddr !== 12'(conv_wr) || o_cdata !== DW'(conv_wr)) conv_bad++;
        conv_wr++;
      end
      if (o_cwr && o_csel) begin
        if (o_caddr !== 12'(pool_wr) || o_cdata !== (19'h40000 | DW'(pool_wr))) pool_bad++;
        pool_wr++;
      end
      if ((o_cwr && !o_csel) !== prev_valid) lat_bad++;
      if (o_l0_go_down) go_cnt++;
      if (o_l0_ready) rdy_cnt++;
      if (done_seen) begin
        busy_after = o_busy;
        break;
      end
      if (!o_busy) busy_bad++;
      if (o_done) begin done_cnt++; done_seen = 1; end
      if (start_next) begin rem = 128; start_next = 0; end
      if (rem > 0) begin
        i_l0_busy = 1; i_l0_valid = 1; i_l0_data = DW'(conv_sent);
        conv_sent++; rem--;
        if (conv_sent % 4 == 0) owed++;
      end else begin
        i_l0_busy = 0; i_l0_valid = 0;
      end
      if (o_l0_ready || o_l0_go_down) start_next = 1;
      prev_valid = i_l0_valid;
      i_pool_valid = (owed > 0);
      i_pool_data = 19'h40000 | DW'(pool_sent);
      if (i_pool_valid && o_pool_ready) begin owed--; pool_sent++; end
      tick();
      cyc++;
    end
    clear_inputs();
    checks++;
    if (!done_seen) begin errors++; $display("FAIL full_timeout got no done exp done within 20000 cycles"); end
    checks++;
    if (conv_wr !== 4096) begin errors++; $display("FAIL full_conv_count got %0d exp 4096", conv_wr); end
    checks++;
    if (conv_bad !== 0) begin errors++; $display("FAIL full_conv_order got %0d bad exp 0", conv_bad); end
    checks++;
    if (lat_bad !== 0) begin errors++; $display("FAIL full_conv_latency got %0d bad exp 0", lat_bad); end
    checks++;
    if (pool_wr !== 1024) begin errors++; $display("FAIL full_pool_count got %0d exp 1024", pool_wr); end
    checks++;
    if (pool_bad !== 0) begin errors++; $display("FAIL full_pool_order got %0d bad exp 0", pool_bad); end
    checks++;
    if (go_cnt !== 31) begin errors++; $display("FAIL full_go_down got %0d exp 31", go_cnt); end
    checks++;
    if (rdy_cnt !== 1) begin errors++; $display("FAIL full_l0_ready got %0d exp 1", rdy_cnt); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL full_done got %0d exp 1", done_cnt); end
    checks++;
    if (busy_bad !== 0) begin errors++; $display("FAIL full_busy_gap got %0d exp 0", busy_bad); end
    checks++;
    if (busy_after !== 1'b0) begin errors++; $display("FAIL full_busy_after got %b exp 0", busy_after); end
  endtask

  initial begin
    test_reset();
    test_relu();
    test_collision();
    test_start_ignored();
    test_pause_flood();
    test_reset_mid();
    test_full_image();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
